// File: rtl/tk3_key_scheduler_pkg.sv
// Shared definitions for the TK3 round-key scheduler: widths, state encoding
// and the byte-level helpers of the TK3 tweakey update.
package tk3_key_scheduler_pkg;

  localparam int TK_W           = 128;
  localparam int RND_W          = 6;
  localparam int NUM_ROUNDS_DEF = 40;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOADED,
    ST_RUN
  } state_e;

  // Source cell for destination cell i; cell 0 is the most significant byte.
  function automatic int tk_perm_src(input int i);
    case (i)
      0:       tk_perm_src = 9;
      1:       tk_perm_src = 15;
      2:       tk_perm_src = 8;
      3:       tk_perm_src = 13;
      4:       tk_perm_src = 10;
      5:       tk_perm_src = 14;
      6:       tk_perm_src = 12;
      7:       tk_perm_src = 11;
      default: tk_perm_src = i - 8;
    endcase
  endfunction

  function automatic logic [7:0] tk3_lfsr(input logic [7:0] b);
    tk3_lfsr = {b[0] ^ b[6], b[7:1]};
  endfunction

endpackage

// File: rtl/tk3_key_scheduler_key_expansion.sv
// One-share TK3 update: cell permutation followed by the TK3 LFSR on the
// top eight cells. Purely combinational and linear, so it may run per share.
module key_expansion
  import tk3_key_scheduler_pkg::*;
(
  input  logic [TK_W-1:0] tk_i,
  output logic [TK_W-1:0] tk_o
);

  logic [TK_W-1:0] perm;

  always_comb begin
    perm = '0;
    for (int i = 0; i < 16; i++) begin
      perm[127-8*i -: 8] = tk_i[127-8*tk_perm_src(i) -: 8];
    end
    tk_o = perm;
    for (int i = 0; i < 8; i++) begin
      tk_o[127-8*i -: 8] = tk3_lfsr(perm[127-8*i -: 8]);
    end
  end

endmodule

// File: rtl/tk3_key_scheduler.sv
// Masked TK3 round-key scheduler; each share evolves through its own key_expansion.
// Optional macro TK3_KEY_CACHE_EN keeps a master copy so a finished block can restart.
module tk3_key_scheduler
  import tk3_key_scheduler_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TK_W-1:0]  key_s0,
  input  logic [TK_W-1:0]  key_s1,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             start,
  input  logic             step,
  input  logic             abort,
  output logic [TK_W-1:0]  rk_s0,
  output logic [TK_W-1:0]  rk_s1,
  output logic             rk_valid,
  output logic [RND_W-1:0] round,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [TK_W-1:0]  s0_q, s0_d, s1_q, s1_d;
  logic [TK_W-1:0]  s0_next, s1_next;
  logic [RND_W-1:0] round_q, round_d;
  logic             done_q, done_d;
`ifdef TK3_KEY_CACHE_EN
  logic [TK_W-1:0]  m0_q, m0_d, m1_q, m1_d;
`endif

  key_expansion u_exp_s0 (.tk_i(s0_q), .tk_o(s0_next));
  key_expansion u_exp_s1 (.tk_i(s1_q), .tk_o(s1_next));

  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef TK3_KEY_CACHE_EN
    m0_d    = m0_q;
    m1_d    = m1_q;
`endif
    if (abort) begin
      state_d = ST_EMPTY;
      s0_d    = '0;
      s1_d    = '0;
      round_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY, ST_LOADED: begin
          // A load always wins over a simultaneous start.
          if (key_valid) begin
            state_d = ST_LOADED;
            s0_d    = key_s0;
            s1_d    = key_s1;
`ifdef TK3_KEY_CACHE_EN
            m0_d    = key_s0;
            m1_d    = key_s1;
`endif
          end else if (start && state_q == ST_LOADED) begin
            state_d = ST_RUN;
            round_d = '0;
          end
        end
        ST_RUN: begin
          if (step) begin
            if (round_q == RND_W'(NUM_ROUNDS - 1)) begin
              done_d  = 1'b1;
              round_d = '0;
`ifdef TK3_KEY_CACHE_EN
              state_d = ST_LOADED;
              s0_d    = m0_q;
              s1_d    = m1_q;
`else
              state_d = ST_EMPTY;
              s0_d    = '0;
              s1_d    = '0;
`endif
            end else begin
              s0_d    = s0_next;
              s1_d    = s1_next;
              round_d = round_q + RND_W'(1);
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      s0_q    <= '0;
      s1_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
`ifdef TK3_KEY_CACHE_EN
      m0_q    <= '0;
      m1_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      round_q <= round_d;
      done_q  <= done_d;
`ifdef TK3_KEY_CACHE_EN
      m0_q    <= m0_d;
      m1_q    <= m1_d;
`endif
    end
  end

  assign key_ready = (state_q != ST_RUN);
  assign rk_valid  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign round     = round_q;
  assign rk_s0     = s0_q;
  assign rk_s1     = s1_q;

endmodule
